// File: rtl/periph_cmd_sequencer.sv
// periph_cmd_sequencer
// Program-driven bus master. Instructions {op[3:0], addr, data} are loaded
// into an internal program RAM while idle and executed on a simple rd/wr
// bus with a ready handshake: NOP, WRITE, READ-compare, WAIT, JUMP, HALT.
// Optional feature macro: BUS_TIMEOUT_EN -- adds a bus-ready watchdog that
// aborts a bus access with error after TIMEOUT_CYC cycles without ready.
module periph_cmd_sequencer #(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 8,
  parameter int PROG_DEPTH  = 16,
  parameter int TIMEOUT_CYC = 64,
  localparam int PC_W    = (PROG_DEPTH > 1) ? $clog2(PROG_DEPTH) : 1,
  localparam int INSTR_W = 4 + ADDR_W + DATA_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               prog_we,
  input  logic [PC_W-1:0]    prog_addr,
  input  logic [INSTR_W-1:0] prog_data,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic               error,
  output logic               mismatch,
  output logic [ADDR_W-1:0]  bus_addr,
  output logic [DATA_W-1:0]  bus_wdata,
  output logic               bus_wr,
  output logic               bus_rd,
  input  logic [DATA_W-1:0]  bus_rdata,
  input  logic               bus_ready
);

  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_WRITE = 4'h1;
  localparam logic [3:0] OP_READ  = 4'h2;
  localparam logic [3:0] OP_WAIT  = 4'h3;
  localparam logic [3:0] OP_JUMP  = 4'h4;
  localparam logic [3:0] OP_HALT  = 4'hF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_BUS,
    S_WAIT
  } state_e;

  // Program storage; not reset, read through a registered port.
  logic [INSTR_W-1:0] mem [PROG_DEPTH];
  logic [INSTR_W-1:0] instr_q;
  logic               mem_we;
  logic               fetch_en;

  state_e             state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [PC_W-1:0]    pc_inc;
  logic [ADDR_W-1:0]  bus_addr_q, bus_addr_d;
  logic [DATA_W-1:0]  bus_wdata_q, bus_wdata_d;
  logic               bus_wr_q, bus_wr_d;
  logic               bus_rd_q, bus_rd_d;
  logic [DATA_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic               done_q, done_d;
  logic               error_q, error_d;
  logic               mismatch_q, mismatch_d;

`ifdef BUS_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TMO_W-1:0]   tmo_cnt_q, tmo_cnt_d;
`endif

  // Decoded fields of the instruction currently being executed.
  logic [3:0]         ir_op;
  logic [ADDR_W-1:0]  ir_addr;
  logic [DATA_W-1:0]  ir_data;
  logic [31:0]        ir_data_ext;
  logic               jump_ok;

  assign ir_op       = instr_q[INSTR_W-1 -: 4];
  assign ir_addr     = instr_q[DATA_W +: ADDR_W];
  assign ir_data     = instr_q[DATA_W-1:0];
  assign ir_data_ext = 32'(ir_data);
  assign jump_ok     = (ir_data_ext < 32'(PROG_DEPTH));

  // PC advances modulo the program depth; no implicit halt at the end.
  assign pc_inc = (pc_q == PC_W'(PROG_DEPTH - 1)) ? '0 : pc_q + PC_W'(1);

  // Loads are only accepted while idle, and a coincident start wins.
  assign mem_we = prog_we && (state_q == S_IDLE) && !start;

  // Program RAM: write port from the loader, registered read for FETCH.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[prog_addr] <= prog_data;
    end
    if (fetch_en) begin
      instr_q <= mem[pc_q];
    end
  end

  // State and output registers; reset clears strobes immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      pc_q        <= '0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      bus_wr_q    <= 1'b0;
      bus_rd_q    <= 1'b0;
      wait_cnt_q  <= '0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      mismatch_q  <= 1'b0;
`ifdef BUS_TIMEOUT_EN
      tmo_cnt_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      bus_wr_q    <= bus_wr_d;
      bus_rd_q    <= bus_rd_d;
      wait_cnt_q  <= wait_cnt_d;
      done_q      <= done_d;
      error_q     <= error_d;
      mismatch_q  <= mismatch_d;
`ifdef BUS_TIMEOUT_EN
      tmo_cnt_q   <= tmo_cnt_d;
`endif
    end
  end

  // Sequencer next-state: fetch, decode, bus handshake and wait counting.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    bus_wr_d    = bus_wr_q;
    bus_rd_d    = bus_rd_q;
    wait_cnt_d  = wait_cnt_q;
    done_d      = 1'b0;
    error_d     = error_q;
    mismatch_d  = mismatch_q;
    fetch_en    = 1'b0;
`ifdef BUS_TIMEOUT_EN
    tmo_cnt_d   = tmo_cnt_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_FETCH;
          pc_d       = '0;
          error_d    = 1'b0;
          mismatch_d = 1'b0;
        end
      end

      S_FETCH: begin
        fetch_en = 1'b1;
        state_d  = S_EXEC;
      end

      S_EXEC: begin
        case (ir_op)
          OP_NOP: begin
            pc_d    = pc_inc;
            state_d = S_FETCH;
          end
          OP_WRITE: begin
            bus_addr_d  = ir_addr;
            bus_wdata_d = ir_data;
            bus_wr_d    = 1'b1;
            state_d     = S_BUS;
`ifdef BUS_TIMEOUT_EN
            tmo_cnt_d   = '0;
`endif
          end
          OP_READ: begin
            bus_addr_d  = ir_addr;
            bus_wdata_d = '0;
            bus_rd_d    = 1'b1;
            state_d     = S_BUS;
`ifdef BUS_TIMEOUT_EN
            tmo_cnt_d   = '0;
`endif
          end
          OP_WAIT: begin
            if (ir_data == '0) begin
              pc_d    = pc_inc;
              state_d = S_FETCH;
            end else begin
              wait_cnt_d = ir_data;
              state_d    = S_WAIT;
            end
          end
          OP_JUMP: begin
            if (jump_ok) begin
              pc_d    = ir_data[PC_W-1:0];
              state_d = S_FETCH;
            end else begin
              error_d = 1'b1;
              state_d = S_IDLE;
            end
          end
          OP_HALT: begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end
          default: begin
            error_d = 1'b1;
            state_d = S_IDLE;
          end
        endcase
      end

      S_BUS: begin
        // Ready takes priority over the watchdog in the same cycle.
        if (bus_ready) begin
          if (bus_rd_q && (bus_rdata != ir_data)) begin
            mismatch_d = 1'b1;
          end
          bus_wr_d = 1'b0;
          bus_rd_d = 1'b0;
          pc_d     = pc_inc;
          state_d  = S_FETCH;
        end
`ifdef BUS_TIMEOUT_EN
        else if (tmo_cnt_q == TMO_W'(TIMEOUT_CYC - 1)) begin
          bus_wr_d = 1'b0;
          bus_rd_d = 1'b0;
          error_d  = 1'b1;
          state_d  = S_IDLE;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
`endif
      end

      S_WAIT: begin
        if (wait_cnt_q == DATA_W'(1)) begin
          pc_d    = pc_inc;
          state_d = S_FETCH;
        end else begin
          wait_cnt_d = wait_cnt_q - DATA_W'(1);
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
  assign error     = error_q;
  assign mismatch  = mismatch_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wdata = bus_wdata_q;
  assign bus_wr    = bus_wr_q;
  assign bus_rd    = bus_rd_q;

endmodule

// File: tb/tb_periph_cmd_sequencer.sv
// Self-checking bench for periph_cmd_sequencer: directed vector table,
// hand-written multi-cycle sequences and randomized programs checked
// against an instruction-level interpreter of the sequencer.
`timescale 1ns/1ps
module tb_periph_cmd_sequencer;

  localparam int ADDR_W      = 8;
  localparam int DATA_W      = 8;
  localparam int PROG_DEPTH  = 16;
  localparam int TIMEOUT_CYC = 64;
  localparam int PC_W        = 4;
  localparam int INSTR_W     = 20;
  localparam logic [19:0] HALT = {4'hF, 8'h00, 8'h00};

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               prog_we = 1'b0;
  logic [PC_W-1:0]    prog_addr = '0;
  logic [INSTR_W-1:0] prog_data = '0;
  logic               start = 1'b0;
  logic [DATA_W-1:0]  bus_rdata = '0;
  logic               bus_ready = 1'b0;
  logic               busy, done, error, mismatch, bus_wr, bus_rd;
  logic [ADDR_W-1:0]  bus_addr;
  logic [DATA_W-1:0]  bus_wdata;

  periph_cmd_sequencer #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .PROG_DEPTH(PROG_DEPTH), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk(clk), .rst(rst), .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
    .start(start), .busy(busy), .done(done), .error(error), .mismatch(mismatch),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_wr(bus_wr), .bus_rd(bus_rd),
    .bus_rdata(bus_rdata), .bus_ready(bus_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       wr;
    logic [7:0] addr;
    logic [7:0] data;
  } tx_t;

  int n_cmp = 0;
  int n_err = 0;
  tx_t dut_log[$];
  tx_t exp_log[$];
  tx_t cur_tx;
  logic [7:0] pregs [256];
  int st [64];
  int tx_idx = 0;
  int stall_cnt = 0;
  logic [INSTR_W-1:0] img [16];

  function automatic logic [19:0] mk(input int op, input int a, input int d);
    return {4'(op), 8'(a), 8'(d)};
  endfunction

  function automatic logic [7:0] init_val(input int a);
    return 8'(a) ^ 8'h04;
  endfunction

  task automatic chk(input string name, input longint act, input longint req);
    n_cmp++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Peripheral: register file with per-transaction ready stall; logs accepts.
  always @(negedge clk) begin
    if (bus_wr || bus_rd) begin
      bus_rdata = pregs[bus_addr];
      if (stall_cnt < st[tx_idx & 63]) begin
        bus_ready = 1'b0;
        stall_cnt++;
      end else begin
        bus_ready   = 1'b1;
        cur_tx.wr   = bus_wr;
        cur_tx.addr = bus_addr;
        cur_tx.data = bus_wr ? bus_wdata : pregs[bus_addr];
        dut_log.push_back(cur_tx);
        if (bus_wr) pregs[bus_addr] = bus_wdata;
        tx_idx++;
      end
    end else begin
      bus_ready = 1'($urandom_range(0, 1));
      bus_rdata = 8'($urandom);
      stall_cnt = 0;
    end
  end

  task automatic load_prog();
    for (int i = 0; i < 16; i++) begin
      prog_we   = 1'b1;
      prog_addr = 4'(i);
      prog_data = img[i];
      @(posedge clk); #1;
    end
    prog_we = 1'b0;
  endtask

  task automatic init_regs();
    for (int a = 0; a < 256; a++) pregs[a] = init_val(a);
    tx_idx = 0;
    dut_log.delete();
  endtask

  task automatic wait_end(input int limit, output int k);
    k = 0;
    while (!(done || error) && k < limit) begin
      @(posedge clk); #1;
      k++;
    end
    if (!(done || error)) begin
      n_cmp++;
      n_err++;
      $display("FAIL run_end: no done/error within %0d cycles", limit);
      rst = 1'b1; #1; rst = 1'b0;
    end
  endtask

  task automatic run(input int limit, output bit d, output bit e, output bit m, output int k);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    chk("error_cleared", error, 0);
    chk("mismatch_cleared", mismatch, 0);
    wait_end(limit, k);
    d = done; e = error; m = mismatch;
    chk("busy_fall", busy, 0);
    @(posedge clk); #1;
    chk("done_pulse_1cyc", done, 0);
  endtask

  // Instruction-level interpreter: each instruction costs FETCH+EXEC plus
  // its own extra cycles; the result is the number of clock edges after
  // the start edge until done/error is visible.
  task automatic model_run(output bit ok, output bit e_done, output bit e_err,
                           output bit e_mis, output int e_cyc);
    logic [7:0] r [256];
    int pc, t, op, a, dv;
    tx_t x;
    for (int i = 0; i < 256; i++) r[i] = init_val(i);
    pc = 0; t = 0; ok = 0; e_done = 0; e_err = 0; e_mis = 0; e_cyc = 0;
    exp_log.delete();
    for (int step = 0; step < 200 && !ok; step++) begin
      op = int'(img[pc][19:16]);
      a  = int'(img[pc][15:8]);
      dv = int'(img[pc][7:0]);
      e_cyc += 2;
      if (op == 0) begin
        pc = (pc + 1) % PROG_DEPTH;
      end else if (op == 1 || op == 2) begin
`ifdef BUS_TIMEOUT_EN
        if (st[t & 63] >= TIMEOUT_CYC) begin
          e_cyc += TIMEOUT_CYC;
          e_err = 1; ok = 1;
          continue;
        end
`endif
        e_cyc += 1 + st[t & 63];
        x.wr = (op == 1); x.addr = 8'(a);
        x.data = (op == 1) ? 8'(dv) : r[a];
        exp_log.push_back(x);
        if (op == 1) r[a] = 8'(dv);
        else if (r[a] != 8'(dv)) e_mis = 1;
        t++;
        pc = (pc + 1) % PROG_DEPTH;
      end else if (op == 3) begin
        e_cyc += dv;
        pc = (pc + 1) % PROG_DEPTH;
      end else if (op == 4) begin
        if (dv >= PROG_DEPTH) begin e_err = 1; ok = 1; end
        else pc = dv;
      end else if (op == 15) begin
        e_done = 1; ok = 1;
      end else begin
        e_err = 1; ok = 1;
      end
    end
  endtask

  task automatic cmp_logs(input string nm);
    chk({nm, "_ntx"}, dut_log.size(), exp_log.size());
    for (int i = 0; i < dut_log.size() && i < exp_log.size(); i++)
      chk({nm, "_tx"}, {dut_log[i].wr, dut_log[i].addr, dut_log[i].data},
          {exp_log[i].wr, exp_log[i].addr, exp_log[i].data});
  endtask

  task automatic gen_prog();
    int r, a;
    for (int i = 0; i < 15; i++) begin
      r = $urandom_range(0, 15);
      a = $urandom_range(0, 7);
      if (r < 2)       img[i] = mk(0, a, $urandom_range(0, 255));
      else if (r < 6)  img[i] = mk(1, a, $urandom_range(0, 255));
      else if (r < 9)  img[i] = mk(2, a, ($urandom_range(0, 1) == 1) ? int'(init_val(a)) : $urandom_range(0, 255));
      else if (r < 11) img[i] = mk(3, 0, $urandom_range(0, 6));
      else if (r < 13) img[i] = mk(4, 0, $urandom_range(0, 19));
      else if (r < 14) img[i] = mk($urandom_range(5, 14), 0, 0);
      else             img[i] = mk(15, 0, 0);
    end
    img[15] = HALT;
  endtask

  typedef struct {
    string       nm;
    logic [19:0] p0, p1, p2, p3;
    bit          ed, ee, em;
    int          ecyc, entx;
  } vec_t;

  vec_t tbl [13];

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    bit d, e, m, ok, ed, ee, em;
    int k, ek, cnt, tries;
    logic [7:0] a0, d0;

    tbl[0]  = '{"wr3",      mk(1,1,5),     mk(1,2,5),  mk(1,3,3),  HALT, 1,0,0, 11, 3};
    tbl[1]  = '{"rd_ok",    mk(2,1,5),     HALT,       HALT,       HALT, 1,0,0,  5, 1};
    tbl[2]  = '{"rd_bad",   mk(2,1,4),     HALT,       HALT,       HALT, 1,0,1,  5, 1};
    tbl[3]  = '{"wait10",   mk(3,0,10),    HALT,       HALT,       HALT, 1,0,0, 14, 0};
    tbl[4]  = '{"wait0",    mk(3,0,0),     HALT,       HALT,       HALT, 1,0,0,  4, 0};
    tbl[5]  = '{"jmp3",     mk(4,0,3),     mk(1,1,1),  mk(1,2,2),  HALT, 1,0,0,  4, 0};
    tbl[6]  = '{"jmp20",    mk(4,0,20),    mk(1,1,1),  HALT,       HALT, 0,1,0,  2, 0};
    tbl[7]  = '{"illegal",  mk(5,0,0),     mk(1,1,1),  HALT,       HALT, 0,1,0,  2, 0};
    tbl[8]  = '{"nop2",     mk(0,0,0),     mk(0,9,9),  HALT,       HALT, 1,0,0,  6, 0};
    tbl[9]  = '{"wr_rd",    mk(1,9,8'h3C), mk(2,9,8'h3C), HALT,    HALT, 1,0,0,  8, 2};
    tbl[10] = '{"jmp15",    mk(4,0,15),    mk(1,1,1),  mk(1,2,2),  mk(1,3,3), 1,0,0, 4, 0};
    tbl[11] = '{"jmp16",    mk(4,0,16),    mk(1,1,1),  HALT,       HALT, 0,1,0,  2, 0};
    tbl[12] = '{"wait3_wr", mk(3,0,3),     mk(1,4,4),  HALT,       HALT, 1,0,0, 10, 1};

    // Asynchronous reset before any clock edge: every output low.
    #2 rst = 1'b1;
    #1;
    chk("rst_busy", busy, 0);         chk("rst_done", done, 0);
    chk("rst_error", error, 0);       chk("rst_mismatch", mismatch, 0);
    chk("rst_bus_wr", bus_wr, 0);     chk("rst_bus_rd", bus_rd, 0);
    chk("rst_bus_addr", bus_addr, 0); chk("rst_bus_wdata", bus_wdata, 0);
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    @(posedge clk); #1;

    // Directed vector table, zero-stall peripheral.
    for (int i = 0; i < 13; i++) begin
      for (int w = 0; w < 16; w++) img[w] = HALT;
      img[0] = tbl[i].p0; img[1] = tbl[i].p1; img[2] = tbl[i].p2; img[3] = tbl[i].p3;
      for (int j = 0; j < 64; j++) st[j] = 0;
      load_prog();
      init_regs();
      run(200, d, e, m, k);
      chk({tbl[i].nm, "_done"}, d, tbl[i].ed);
      chk({tbl[i].nm, "_error"}, e, tbl[i].ee);
      chk({tbl[i].nm, "_mismatch"}, m, tbl[i].em);
      chk({tbl[i].nm, "_cycles"}, k, tbl[i].ecyc);
      chk({tbl[i].nm, "_ntx"}, dut_log.size(), tbl[i].entx);
      $display("vec %-9s done=%0d error=%0d mismatch=%0d cycles=%0d ntx=%0d",
               tbl[i].nm, d, e, m, k, dut_log.size());
    end

    // Three writes land in order with the programmed address/data.
    for (int w = 0; w < 16; w++) img[w] = HALT;
    img[0] = mk(1,1,5); img[1] = mk(1,2,5); img[2] = mk(1,3,3);
    load_prog(); init_regs();
    run(200, d, e, m, k);
    chk("wr3_count", dut_log.size(), 3);
    if (dut_log.size() == 3) begin
      chk("wr3_tx0", {dut_log[0].wr, dut_log[0].addr, dut_log[0].data}, {1'b1, 8'h01, 8'h05});
      chk("wr3_tx1", {dut_log[1].wr, dut_log[1].addr, dut_log[1].data}, {1'b1, 8'h02, 8'h05});
      chk("wr3_tx2", {dut_log[2].wr, dut_log[2].addr, dut_log[2].data}, {1'b1, 8'h03, 8'h03});
    end
    $display("seq wr3_order ntx=%0d", dut_log.size());

    // Ready held low 3 cycles: strobe, address and data stable for 4 cycles.
    for (int w = 0; w < 16; w++) img[w] = HALT;
    img[0] = mk(1, 8'h22, 8'h99);
    for (int j = 0; j < 64; j++) st[j] = 0;
    st[0] = 3;
    load_prog(); init_regs();
    start = 1'b1; @(posedge clk); #1; start = 1'b0;
    cnt = 0; k = 0;
    while (!done && k < 50) begin
      @(posedge clk); #1; k++;
      if (bus_wr) begin
        cnt++;
        chk("stall_addr", bus_addr, 8'h22);
        chk("stall_wdata", bus_wdata, 8'h99);
      end
    end
    chk("stall_wr_cycles", cnt, 4);
    chk("stall_ntx", dut_log.size(), 1);
    chk("stall_done_cycles", k, 8);
    $display("seq stall3 wr_cycles=%0d cycles=%0d", cnt, k);
    st[0] = 0;

    // Reset asserted mid-WRITE: outputs drop before the next clock edge.
    for (int w = 0; w < 16; w++) img[w] = HALT;
    img[0] = mk(1, 8'h11, 8'h77);
    st[0] = 1000;
    load_prog(); init_regs();
    start = 1'b1; @(posedge clk); #1; start = 1'b0;
    k = 0;
    while (!bus_wr && k < 10) begin @(posedge clk); #1; k++; end
    chk("midrst_saw_wr", bus_wr, 1);
    #3 rst = 1'b1;
    #1;
    chk("midrst_bus_wr", bus_wr, 0);     chk("midrst_bus_addr", bus_addr, 0);
    chk("midrst_bus_wdata", bus_wdata, 0); chk("midrst_busy", busy, 0);
    chk("midrst_bus_rd", bus_rd, 0);     chk("midrst_done", done, 0);
    @(posedge clk); #2 rst = 1'b0;
    @(posedge clk); #1;
    st[0] = 0;
    init_regs();
    run(200, d, e, m, k);
    chk("midrst_ram_kept", dut_log.size(), 1);
    $display("seq midrst rerun ntx=%0d done=%0d", dut_log.size(), d);

    // start and prog_we together in IDLE: start wins, RAM unchanged.
    for (int w = 0; w < 16; w++) img[w] = HALT;
    img[0] = mk(1, 8'h07, 8'h07);
    load_prog(); init_regs();
    start = 1'b1; prog_we = 1'b1; prog_addr = '0; prog_data = HALT;
    @(posedge clk); #1;
    start = 1'b0; prog_we = 1'b0;
    wait_end(100, k);
    chk("startwe_ntx", dut_log.size(), 1);
    @(posedge clk); #1;
    init_regs();
    run(200, d, e, m, k);
    chk("startwe_rerun_ntx", dut_log.size(), 1);
    $display("seq start_with_prog_we ntx=%0d", dut_log.size());

    // prog_we while busy is ignored.
    for (int w = 0; w < 16; w++) img[w] = HALT;
    img[0] = mk(1, 8'h08, 8'h08);
    st[0] = 5;
    load_prog(); init_regs();
    start = 1'b1; @(posedge clk); #1; start = 1'b0;
    prog_we = 1'b1; prog_addr = '0; prog_data = HALT;
    @(posedge clk); #1;
    prog_we = 1'b0;
    wait_end(100, k);
    st[0] = 0;
    @(posedge clk); #1;
    init_regs();
    run(200, d, e, m, k);
    chk("busywe_ntx", dut_log.size(), 1);
    a0 = (dut_log.size() > 0) ? dut_log[0].addr : 8'h00;
    chk("busywe_addr", a0, 8'h08);
    $display("seq prog_we_while_busy ntx=%0d addr=0x%0h", dut_log.size(), a0);

    // Long ready stall (beyond the watchdog limit when it is built in).
    for (int w = 0; w < 16; w++) img[w] = HALT;
    img[0] = mk(1, 8'h30, 8'hAB);
    for (int j = 0; j < 64; j++) st[j] = 0;
    st[0] = 100;
    model_run(ok, ed, ee, em, ek);
    load_prog(); init_regs();
    run(400, d, e, m, k);
    chk("longstall_done", d, ed);
    chk("longstall_error", e, ee);
    chk("longstall_cycles", k, ek);
    chk("longstall_bus_wr", bus_wr, 0);
    cmp_logs("longstall");
    $display("seq longstall done=%0d error=%0d cycles=%0d", d, e, k);

    // Randomized programs and peripheral stalls against the interpreter.
    for (int it = 0; it < 40; it++) begin
      tries = 0;
      ok = 0;
      while (!ok && tries < 50) begin
        gen_prog();
        for (int j = 0; j < 64; j++) st[j] = $urandom_range(0, 3);
        model_run(ok, ed, ee, em, ek);
        tries++;
      end
      if (!ok) begin
        img[0] = HALT;
        model_run(ok, ed, ee, em, ek);
      end
      load_prog(); init_regs();
      run(3000, d, e, m, k);
      chk("rand_done", d, ed);
      chk("rand_error", e, ee);
      chk("rand_mismatch", m, em);
      chk("rand_cycles", k, ek);
      cmp_logs("rand");
      d0 = 8'(dut_log.size());
      $display("rand %0d done=%0d error=%0d mismatch=%0d cycles=%0d ntx=%0d", it, d, e, m, k, d0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
